uart_duplex: RTL
================

UART_DUPLEX -- requirements
Module: uart_duplex

Interface
REQ-001 Parameter DBIT, 8, data bits per frame (5..8).
REQ-002 Parameter SB_TICK, 16, stop-bit length in oversample ticks (16/24/32 = 1/1.5/2 stop bits).
REQ-003 Parameter CLK_DIV, 27, clk cycles per 16x oversample tick (>=2).
REQ-004 Parameter PARITY, 0, 0 none / 1 even / 2 odd.
REQ-005 Parameter FIFO_AW, 4, FIFO address width; each FIFO depth 2**FIFO_AW.
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 rx  in  1  serial input, asynchronous, idle high.
REQ-009 tx  out  1  serial output, idle high.
REQ-010 wr_uart  in  1  push w_data into TX FIFO.
REQ-011 w_data  in  8  TX byte; bits above DBIT-1 ignored.
REQ-012 tx_full / tx_empty  out  1 each  TX FIFO status.
REQ-013 rd_uart  in  1  pop RX FIFO head.
REQ-014 r_data  out  8  RX FIFO head (first-word fall-through), upper bits zero when DBIT<8.
REQ-015 rx_full / rx_empty  out  1 each  RX FIFO status.
REQ-016 parity_err, frame_err, overrun_err  out  1 each  sticky error flags.
REQ-017 clr_err  in  1  clears all three error flags.

Function
REQ-018 Baud counter SHALL count 0..CLK_DIV-1 and pulse tick for one clk at CLK_DIV-1, free-running.
REQ-019 FIFOs: write when full ignored unless rd same cycle; read when empty ignored; simultaneous rd+wr when non-empty keeps count; pointers wrap modulo depth.
REQ-020 TX FSM states IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY=0.
REQ-021 IDLE->START when TX FIFO non-empty; byte latched into shift register on that transition.
REQ-022 START/DATA/PARITY each last 16 ticks; data LSB first; STOP lasts SB_TICK ticks, tx=1.
REQ-023 TX FIFO SHALL be popped exactly once, in the clk the frame's STOP ends; next frame may start the following tick-aligned START with no idle gap.
REQ-024 Parity bit = XOR of DBIT data bits (even) or its inverse (odd).
REQ-025 rx SHALL pass a 2-flop synchronizer before use.
REQ-026 RX FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START on synchronized rx=0.
REQ-027 START: at 8th tick re-sample; rx=1 -> IDLE (glitch, no byte, no flag); else reset tick count, go DATA.
REQ-028 DATA/PARITY bits sampled at 16th tick (bit centre); STOP sampled at 16th tick of stop bit regardless of SB_TICK.
REQ-029 On STOP sample: write byte to RX FIFO; stop=0 sets frame_err; parity mismatch sets parity_err; byte still stored in both cases.
REQ-030 If RX FIFO full at write (and no rd same cycle), byte SHALL be dropped and overrun_err set.
REQ-031 clr_err clears flags; a new error in the same cycle as clr_err wins (flag set).
REQ-032 TX and RX SHALL operate independently and concurrently.

Reset
REQ-033 reset: tx=1, both FSMs IDLE, baud counter 0, FIFOs empty (tx_empty=rx_empty=1, full=0), r_data=0, all error flags 0.
REQ-034 reset mid-frame SHALL abort the frame immediately; tx=1 next cycle; partially received byte discarded.

Verification (CLK_DIV=4, FIFO_AW=2 unless stated)
REQ-035 Write 0xA5, PARITY=0 -> tx: start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 64 clk; tx_empty=1 after stop.
REQ-036 Loopback tx->rx, write 0x00,0xFF,0x3C,0x81 -> read back same order, no error flags.
REQ-037 Write 5 bytes back-to-back at depth 4 while TX idle -> tx_full after 4th, 5th ignored; only 4 frames sent; no gaps between frames.
REQ-038 PARITY=1, inject 0x07 with wrong parity -> byte stored, parity_err=1; clr_err -> 0.
REQ-039 Inject frame with stop=0 -> frame_err=1; inject 5 frames without reading -> overrun_err=1, first 4 bytes intact.
REQ-040 rx low pulse of 4 ticks -> no byte, no flags; reset asserted mid-TX frame -> tx=1 next clk, tx_empty=1.

Source files
------------

// File: rtl/uart_duplex_if.sv
// Host-side bus of the full-duplex UART: TX/RX FIFO access, status and sticky error flags.
interface uart_duplex_if;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       tx_full;
  logic       tx_empty;
  logic       rd_uart;
  logic [7:0] r_data;
  logic       rx_full;
  logic       rx_empty;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       clr_err;

  modport master (
    output wr_uart, w_data, rd_uart, clr_err,
    input  tx_full, tx_empty, r_data, rx_full, rx_empty, parity_err, frame_err, overrun_err
  );

  modport slave (
    input  wr_uart, w_data, rd_uart, clr_err,
    output tx_full, tx_empty, r_data, rx_full, rx_empty, parity_err, frame_err, overrun_err
  );
endinterface

// File: rtl/uart_duplex.sv
// Full-duplex UART: shared 16x baud tick, TX/RX FIFOs, frame FSMs with optional parity.
// TX peeks the FIFO entry behind the head so back-to-back frames have no idle gap.
module uart_duplex #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned CLK_DIV = 27,
  parameter int unsigned PARITY  = 0,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic tx,
  uart_duplex_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned BW    = $clog2(CLK_DIV);
  localparam logic [7:0]  DMASK = 8'((9'd1 << DBIT) - 9'd1);
  localparam logic        ODD   = 1'(PARITY == 2);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_e;

  logic [BW-1:0] baud_q, baud_d;
  logic          tick_c;
  logic          rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;

  logic [7:0]         tf_mem_q [DEPTH];
  logic [7:0]         tf_mem_d [DEPTH];
  logic [FIFO_AW-1:0] tf_wp_q, tf_wp_d, tf_rp_q, tf_rp_d, tf_rp_nx;
  logic [CW-1:0]      tf_cnt_q, tf_cnt_d;
  logic               tf_full_q, tf_full_d, tf_empty_q, tf_empty_d, tf_wr_c;
  logic [7:0]         tf_head_c, tf_next_c;

  logic [7:0]         rf_mem_q [DEPTH];
  logic [7:0]         rf_mem_d [DEPTH];
  logic [FIFO_AW-1:0] rf_wp_q, rf_wp_d, rf_rp_q, rf_rp_d;
  logic [CW-1:0]      rf_cnt_q, rf_cnt_d;
  logic               rf_full_q, rf_full_d, rf_empty_q, rf_empty_d, rf_wr_c, rf_rd_c;

  state_e     tx_state_q, tx_state_d;
  logic [4:0] tx_s_q, tx_s_d;
  logic [2:0] tx_n_q, tx_n_d;
  logic [7:0] tx_b_q, tx_b_d;
  logic       tx_par_q, tx_par_d, tx_q, tx_d, tx_pop_c;

  state_e     rx_state_q, rx_state_d;
  logic [4:0] rx_s_q, rx_s_d;
  logic [2:0] rx_n_q, rx_n_d;
  logic [7:0] rx_b_q, rx_b_d, rx_byte_c;
  logic       rx_pbit_q, rx_pbit_d, rx_wr_c, frame_new_c, par_new_c, ovr_new_c;
  logic       perr_q, perr_d, ferr_q, ferr_d, oerr_q, oerr_d;

  // Free-running oversample tick and rx synchronizer
  always_comb begin
    tick_c    = (baud_q == BW'(CLK_DIV - 1));
    baud_d    = tick_c ? '0 : baud_q + 1'b1;
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
  end

  // TX FIFO
  always_comb begin
    tf_mem_d  = tf_mem_q;
    tf_wp_d   = tf_wp_q;
    tf_rp_d   = tf_rp_q;
    tf_cnt_d  = tf_cnt_q;
    tf_rp_nx  = tf_rp_q + 1'b1;
    tf_head_c = tf_mem_q[tf_rp_q];
    tf_next_c = tf_mem_q[tf_rp_nx];
    tf_wr_c   = bus.wr_uart && (!tf_full_q || tx_pop_c);
    if (tf_wr_c) begin
      tf_mem_d[tf_wp_q] = bus.w_data & DMASK;
      tf_wp_d           = tf_wp_q + 1'b1;
    end
    if (tx_pop_c) tf_rp_d = tf_rp_nx;
    if (tf_wr_c && !tx_pop_c)      tf_cnt_d = tf_cnt_q + 1'b1;
    else if (!tf_wr_c && tx_pop_c) tf_cnt_d = tf_cnt_q - 1'b1;
    tf_full_d  = (tf_cnt_d == CW'(DEPTH));
    tf_empty_d = (tf_cnt_d == '0);
  end

  // RX FIFO; a byte arriving while full is dropped unless a read frees a slot
  always_comb begin
    rf_mem_d = rf_mem_q;
    rf_wp_d  = rf_wp_q;
    rf_rp_d  = rf_rp_q;
    rf_cnt_d = rf_cnt_q;
    rf_rd_c  = bus.rd_uart && !rf_empty_q;
    rf_wr_c  = rx_wr_c && (!rf_full_q || bus.rd_uart);
    if (rf_wr_c) begin
      rf_mem_d[rf_wp_q] = rx_byte_c;
      rf_wp_d           = rf_wp_q + 1'b1;
    end
    if (rf_rd_c) rf_rp_d = rf_rp_q + 1'b1;
    if (rf_wr_c && !rf_rd_c)      rf_cnt_d = rf_cnt_q + 1'b1;
    else if (!rf_wr_c && rf_rd_c) rf_cnt_d = rf_cnt_q - 1'b1;
    rf_full_d  = (rf_cnt_d == CW'(DEPTH));
    rf_empty_d = (rf_cnt_d == '0);
  end

  // TX frame FSM; all transitions are tick-aligned so every bit is exactly 16 ticks
  always_comb begin
    tx_state_d = tx_state_q;
    tx_s_d     = tx_s_q;
    tx_n_d     = tx_n_q;
    tx_b_d     = tx_b_q;
    tx_par_d   = tx_par_q;
    tx_pop_c   = 1'b0;
    tx_d       = 1'b1;
    if (tick_c) begin
      case (tx_state_q)
        ST_IDLE: if (!tf_empty_q) begin
          tx_state_d = ST_START;
          tx_s_d     = '0;
          tx_b_d     = tf_head_c;
          tx_par_d   = (^tf_head_c) ^ ODD;
        end
        ST_START: if (tx_s_q == 5'd15) begin
          tx_state_d = ST_DATA;
          tx_s_d     = '0;
          tx_n_d     = '0;
        end else tx_s_d = tx_s_q + 1'b1;
        ST_DATA: if (tx_s_q == 5'd15) begin
          tx_s_d = '0;
          tx_b_d = tx_b_q >> 1;
          if (tx_n_q == 3'(DBIT - 1)) tx_state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
          else                        tx_n_d     = tx_n_q + 1'b1;
        end else tx_s_d = tx_s_q + 1'b1;
        ST_PAR: if (tx_s_q == 5'd15) begin
          tx_state_d = ST_STOP;
          tx_s_d     = '0;
        end else tx_s_d = tx_s_q + 1'b1;
        ST_STOP: if (tx_s_q == 5'(SB_TICK - 1)) begin
          tx_pop_c = 1'b1;
          tx_s_d   = '0;
          if (tf_cnt_q > CW'(1)) begin
            tx_state_d = ST_START;
            tx_b_d     = tf_next_c;
            tx_par_d   = (^tf_next_c) ^ ODD;
          end else tx_state_d = ST_IDLE;
        end else tx_s_d = tx_s_q + 1'b1;
        default: tx_state_d = ST_IDLE;
      endcase
    end
    case (tx_state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = tx_b_d[0];
      ST_PAR:   tx_d = tx_par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // RX frame FSM; data shifts in from the top, then realigns for DBIT < 8
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_s_d      = rx_s_q;
    rx_n_d      = rx_n_q;
    rx_b_d      = rx_b_q;
    rx_pbit_d   = rx_pbit_q;
    rx_wr_c     = 1'b0;
    frame_new_c = 1'b0;
    par_new_c   = 1'b0;
    rx_byte_c   = 8'(rx_b_q >> (8 - DBIT));
    case (rx_state_q)
      ST_IDLE: if (!rx_sync_q) begin
        rx_state_d = ST_START;
        rx_s_d     = '0;
      end
      ST_START: if (tick_c) begin
        if (rx_s_q == 5'd7) begin
          rx_s_d = '0;
          rx_n_d = '0;
          rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
        end else rx_s_d = rx_s_q + 1'b1;
      end
      ST_DATA: if (tick_c) begin
        if (rx_s_q == 5'd15) begin
          rx_s_d = '0;
          rx_b_d = {rx_sync_q, rx_b_q[7:1]};
          if (rx_n_q == 3'(DBIT - 1)) rx_state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
          else                        rx_n_d     = rx_n_q + 1'b1;
        end else rx_s_d = rx_s_q + 1'b1;
      end
      ST_PAR: if (tick_c) begin
        if (rx_s_q == 5'd15) begin
          rx_s_d     = '0;
          rx_pbit_d  = rx_sync_q;
          rx_state_d = ST_STOP;
        end else rx_s_d = rx_s_q + 1'b1;
      end
      ST_STOP: if (tick_c) begin
        if (rx_s_q == 5'd15) begin
          rx_wr_c     = 1'b1;
          frame_new_c = !rx_sync_q;
          par_new_c   = (PARITY != 0) && (rx_pbit_q != ((^rx_byte_c) ^ ODD));
          rx_state_d  = ST_IDLE;
        end else rx_s_d = rx_s_q + 1'b1;
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // Sticky errors; a new error beats a same-cycle clear
  always_comb begin
    ovr_new_c = rx_wr_c && rf_full_q && !bus.rd_uart;
    perr_d    = par_new_c   || (perr_q && !bus.clr_err);
    ferr_d    = frame_new_c || (ferr_q && !bus.clr_err);
    oerr_d    = ovr_new_c   || (oerr_q && !bus.clr_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      baud_q     <= '0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      tf_mem_q   <= '{default: '0};
      tf_wp_q    <= '0;
      tf_rp_q    <= '0;
      tf_cnt_q   <= '0;
      tf_full_q  <= 1'b0;
      tf_empty_q <= 1'b1;
      rf_mem_q   <= '{default: '0};
      rf_wp_q    <= '0;
      rf_rp_q    <= '0;
      rf_cnt_q   <= '0;
      rf_full_q  <= 1'b0;
      rf_empty_q <= 1'b1;
      tx_state_q <= ST_IDLE;
      tx_s_q     <= '0;
      tx_n_q     <= '0;
      tx_b_q     <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_s_q     <= '0;
      rx_n_q     <= '0;
      rx_b_q     <= '0;
      rx_pbit_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      oerr_q     <= 1'b0;
    end else begin
      baud_q     <= baud_d;
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      tf_mem_q   <= tf_mem_d;
      tf_wp_q    <= tf_wp_d;
      tf_rp_q    <= tf_rp_d;
      tf_cnt_q   <= tf_cnt_d;
      tf_full_q  <= tf_full_d;
      tf_empty_q <= tf_empty_d;
      rf_mem_q   <= rf_mem_d;
      rf_wp_q    <= rf_wp_d;
      rf_rp_q    <= rf_rp_d;
      rf_cnt_q   <= rf_cnt_d;
      rf_full_q  <= rf_full_d;
      rf_empty_q <= rf_empty_d;
      tx_state_q <= tx_state_d;
      tx_s_q     <= tx_s_d;
      tx_n_q     <= tx_n_d;
      tx_b_q     <= tx_b_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      rx_state_q <= rx_state_d;
      rx_s_q     <= rx_s_d;
      rx_n_q     <= rx_n_d;
      rx_b_q     <= rx_b_d;
      rx_pbit_q  <= rx_pbit_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      oerr_q     <= oerr_d;
    end
  end

  assign tx              = tx_q;
  assign bus.tx_full     = tf_full_q;
  assign bus.tx_empty    = tf_empty_q;
  assign bus.rx_full     = rf_full_q;
  assign bus.rx_empty    = rf_empty_q;
  assign bus.r_data      = rf_empty_q ? 8'h00 : rf_mem_q[rf_rp_q];
  assign bus.parity_err  = perr_q;
  assign bus.frame_err   = ferr_q;
  assign bus.overrun_err = oerr_q;
endmodule
